inst_fetch_queue: RTL
=====================

Name: inst_fetch_queue

Overview:
Instruction-fetch front end and the producer side of the decoder's instruction queue interface. Keeps the fetch PC and issues one word fetch at a time to the memory controller. Buffers returned instructions with their PCs in a circular FIFO. Presents the FIFO head to the decoder, which pops it with re_i; a redirect from commit flushes the FIFO and restarts fetch.

Parameters:
DEPTH, 16, FIFO entries; power of two, at least 2
PTR_W, 4, log2(DEPTH)
RESET_PC, 32'h0, fetch address after reset

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
rdy  in  1  global enable; low freezes all state
re_i  in  1  decoder pop request for the head entry
inst_o  out  32  head instruction
pc_o  out  32  head instruction PC
inst_empty_o  out  1  FIFO holds no valid entry
mem_req_o  out  1  word fetch request outstanding
mem_addr_o  out  32  fetch address
mem_done_i  in  1  one-cycle pulse: mem_data_i valid, request complete
mem_data_i  in  32  fetched word
jump_en_i  in  1  redirect/flush pulse from commit
jump_pc_i  in  32  redirect target

Behaviour:
- Reset (rst=1 at posedge):
  - head=tail=count=0; fetch_pc=RESET_PC; state=IDLE
  - mem_req_o=0, mem_addr_o=0, inst_empty_o=1, inst_o=0, pc_o=0
  - Reset mid-fetch abandons the request; the memory controller is reset by the same rst.
- rdy=0: no state changes; outputs hold; mem_done_i is not sampled.
- FIFO outputs:
  - inst_o/pc_o = storage[head], combinational from registered state.
  - inst_empty_o = (count==0).
  - inst_o/pc_o are don't-care when empty.
- Pop: re_i && !inst_empty_o at posedge, head+1 mod DEPTH, count-1. re_i while empty is ignored.
- FSM states: IDLE, WAIT, DROP.
  - IDLE:
    - if count<DEPTH and !jump_en_i: mem_req_o<=1, mem_addr_o<=fetch_pc, go to WAIT.
    - Request appears the cycle after the decision.
  - WAIT:
    - mem_req_o and mem_addr_o held stable.
    - On mem_done_i: write {mem_data_i, mem_addr_o} at tail, tail+1, count+1, fetch_pc<=fetch_pc+4, mem_req_o<=0, go to IDLE.
  - DROP:
    - mem_req_o held, no push.
    - On mem_done_i: discard the data, mem_req_o<=0, go to IDLE.
- Capacity: issue only when count<DEPTH. Only one request is outstanding and count cannot grow during WAIT, so a push always has a free slot. Overflow is impossible; no full output.
- Simultaneous push and pop: count unchanged, both pointers advance. When count==0, the pushed entry becomes visible the next cycle. Same-cycle bypass is not required.
- Fetch latency:
  - Minimum two cycles from issue to push with single-cycle mem_done.
  - After a push, IDLE re-issues the next cycle.
  - Throughput is one word per (memory latency + 1) cycles.
- Flush (jump_en_i=1): highest priority; pop and push in the same cycle are cancelled.
  - head=tail=count=0, fetch_pc<=jump_pc_i.
  - IDLE: stay IDLE, no request this cycle.
  - WAIT without mem_done_i: go to DROP.
  - WAIT with mem_done_i: discard data, mem_req_o<=0, go to IDLE.
  - DROP: stays DROP, or goes IDLE if mem_done_i; fetch_pc takes the latest jump_pc_i.
- Pointers wrap modulo DEPTH; fetch_pc wraps modulo 2^32.
- Memory contract:
  - The controller may not drop an accepted request.
  - mem_done_i is never asserted while mem_req_o=0; if it is, it is ignored.

Decomposition:
- Shared package: opcode-independent constants INST_W=32, ADDR_W=32, NOP word 32'h00000013, FSM state encoding.
- One sub-module is natural: fifo_ptr_ctrl (head/tail/count update with pop/push/flush priority). Storage array and FSM stay in the top.

Test Plan:
- Reset then rdy=1 with mem_done one cycle after each request: mem_addr_o sequence 0x0,0x4,0x8. Head shows pc_o=0x0, inst_o=first word, 2 cycles after the first request.
- No pops with DEPTH=16: exactly 16 pushes, mem_req_o stays 0 afterwards. One re_i pulse triggers request at addr 0x40 the following cycle.
- Flush while WAIT (jump_pc_i=0x1000), mem_done 3 cycles later: inst_empty_o=1, the returned word is not enqueued, next request addr=0x1000.
- jump_en_i coincident with mem_done_i and re_i: FIFO empty, no push, next request addr=jump_pc_i.
- Simultaneous push and pop at count=1: count stays 1, head advances. Repeat across the pointer wrap at entry 15 to 0 with correct pc_o.
- rdy=0 for 5 cycles mid-WAIT with mem_done pulsed: no push, state and outputs unchanged. Resumes when rdy=1.

Source files
------------

// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants and fetch FSM encoding for the instruction fetch queue.
package inst_fetch_queue_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam logic [INST_W-1:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch_queue_fifo_ptr_ctrl.sv
// Head/tail/count bookkeeping for the fetch FIFO; flush outranks push and pop.
module inst_fetch_queue_fifo_ptr_ctrl #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PTR_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    output logic [PTR_W-1:0] head,
    output logic [PTR_W-1:0] tail,
    output logic [PTR_W:0]   count,
    output logic             empty
);

    logic pop_ok;

    assign empty  = (count == '0);
    assign pop_ok = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy) begin
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (pop_ok) head <= head + PTR_W'(1);
                if (push)   tail <= tail + PTR_W'(1);
                case ({push, pop_ok})
                    2'b10:   count <= count + (PTR_W+1)'(1);
                    2'b01:   count <= count - (PTR_W+1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: single-outstanding word fetch feeding a circular
// FIFO of {instruction, PC} presented to the decoder.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned PTR_W    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              re_i,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              inst_empty_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_done_i,
    input  logic [INST_W-1:0] mem_data_i,
    input  logic              jump_en_i,
    input  logic [ADDR_W-1:0] jump_pc_i
);

    fetch_state_t      state, state_n;
    logic [ADDR_W-1:0] fetch_pc, fetch_pc_n;
    logic [ADDR_W-1:0] addr_n;
    logic              req_n;
    logic              push;

    logic [PTR_W-1:0]  head, tail;
    logic [PTR_W:0]    count;
    logic              empty;

    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];

    inst_fetch_queue_fifo_ptr_ctrl #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ptr_ctrl (
        .clk   (clk),
        .rst   (rst),
        .rdy   (rdy),
        .push  (push),
        .pop   (re_i),
        .flush (jump_en_i),
        .head  (head),
        .tail  (tail),
        .count (count),
        .empty (empty)
    );

    // Storage is never reset; the head is masked to zero while empty instead.
    always_ff @(posedge clk) begin
        if (rdy && push) begin
            inst_mem[tail] <= mem_data_i;
            pc_mem[tail]   <= mem_addr_o;
        end
    end

    assign inst_empty_o = empty;
    assign inst_o       = empty ? '0 : inst_mem[head];
    assign pc_o         = empty ? '0 : pc_mem[head];

    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        req_n      = mem_req_o;
        addr_n     = mem_addr_o;
        push       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (jump_en_i) begin
                    fetch_pc_n = jump_pc_i;
                end else if (count < (PTR_W+1)'(DEPTH)) begin
                    req_n   = 1'b1;
                    addr_n  = fetch_pc;
                    state_n = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (jump_en_i) begin
                    fetch_pc_n = jump_pc_i;
                    if (mem_done_i) begin
                        req_n   = 1'b0;
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_DROP;
                    end
                end else if (mem_done_i) begin
                    push       = 1'b1;
                    fetch_pc_n = fetch_pc + 32'd4;
                    req_n      = 1'b0;
                    state_n    = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (jump_en_i) fetch_pc_n = jump_pc_i;
                if (mem_done_i) begin
                    req_n   = 1'b0;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            fetch_pc   <= RESET_PC;
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
        end else if (rdy) begin
            state      <= state_n;
            fetch_pc   <= fetch_pc_n;
            mem_req_o  <= req_n;
            mem_addr_o <= addr_n;
        end
    end

endmodule
